// File: rtl/ov7670_capture_param.sv
// OV7670 pixel-bus capture into a frame-buffer write port: configurable geometry,
// power-of-two decimation, RGB565 / YUV422-luma select. Optional line-length check: OV7670_CAPTURE_LINE_CHECK_EN.
module ov7670_capture_param #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 2,
  parameter int CH_W     = 4,
  parameter int ADDR_W   = 17
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                vsync,
  input  logic                href,
  input  logic [7:0]          d,
  input  logic                fmt,
  output logic [ADDR_W-1:0]   addr,
  output logic [3*CH_W-1:0]   dout,
  output logic                we,
  output logic                frame_done
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
  ,
  output logic                err
`endif
);

  localparam int X_W = $clog2(H_ACTIVE + 1);
  localparam int Y_W = $clog2(V_ACTIVE + 1);
  localparam logic [X_W-1:0] X_LIM  = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] Y_LIM  = Y_W'(V_ACTIVE);
  localparam logic [X_W-1:0] X_MASK = X_W'(DECIM - 1);
  localparam logic [Y_W-1:0] Y_MASK = Y_W'(DECIM - 1);

  typedef enum logic {
    ST_UNARMED = 1'b0,
    ST_ARMED   = 1'b1
  } cap_state_e;

  cap_state_e          state_q, state_d;
  logic                vsync_q, vsync_d;
  logic                href_q, href_d;
  logic                fmt_q, fmt_d;
  logic                phase_q, phase_d;
  logic [7:0]          b0_q, b0_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic                wrote_any_q, wrote_any_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3*CH_W-1:0]   dout_q, dout_d;
  logic                we_q, we_d;
  logic                frame_done_q, frame_done_d;

`ifdef OV7670_CAPTURE_LINE_CHECK_EN
  localparam int C_W = $clog2(2 * H_ACTIVE + 2);
  localparam logic [C_W-1:0] C_LIM = C_W'(2 * H_ACTIVE);
  logic [C_W-1:0]      cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  logic                vsync_rise;
  logic                store_ok;
  logic [5:0]          g6;
  logic [3*CH_W-1:0]   pix;

  assign vsync_rise = vsync & ~vsync_q;
  assign store_ok   = (state_q == ST_ARMED) && (x_q < X_LIM) && (y_q < Y_LIM) &&
                      ((x_q & X_MASK) == '0) && ((y_q & Y_MASK) == '0);

  // Pixel is assembled from the latched first byte and the byte on the bus now.
  assign g6  = {b0_q[2:0], d[7:5]};
  assign pix = fmt_q ? {3{b0_q[7 -: CH_W]}}
                     : {b0_q[7 -: CH_W], g6[5 -: CH_W], d[4 -: CH_W]};

  // Low-order colour bits are deliberately discarded when CH_W is narrow.
  logic unused_bits;
  assign unused_bits = ^{b0_q, d, g6};

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    vsync_d      = vsync;
    href_d       = href;
    fmt_d        = fmt_q;
    phase_d      = phase_q;
    b0_d         = b0_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_cnt_d   = addr_cnt_q;
    wrote_any_d  = wrote_any_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    we_d         = 1'b0;
    frame_done_d = 1'b0;
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif

    if (vsync) begin
      state_d    = ST_ARMED;
      fmt_d      = fmt;
      phase_d    = 1'b0;
      x_d        = '0;
      y_d        = '0;
      addr_cnt_d = '0;
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
      cnt_d      = '0;
`endif
      if (vsync_rise) begin
        frame_done_d = wrote_any_q;
        wrote_any_d  = 1'b0;
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
        err_d        = 1'b0;
`endif
      end
    end else if (href) begin
      phase_d = ~phase_q;
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
      if (cnt_q <= C_LIM) cnt_d = cnt_q + C_W'(1);
`endif
      if (!phase_q) begin
        b0_d = d;
      end else begin
        if (x_q < X_LIM) x_d = x_q + X_W'(1);
        if (store_ok) begin
          we_d        = 1'b1;
          dout_d      = pix;
          addr_d      = addr_cnt_q;
          addr_cnt_d  = addr_cnt_q + ADDR_W'(1);
          wrote_any_d = 1'b1;
        end
      end
    end else begin
      phase_d = 1'b0;
      if (href_q) begin
        x_d = '0;
        if (y_q < Y_LIM) y_d = y_q + Y_W'(1);
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
        if ((y_q < Y_LIM) && (cnt_q != C_LIM)) err_d = 1'b1;
        cnt_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge pclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= ST_UNARMED;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      fmt_q        <= 1'b0;
      phase_q      <= 1'b0;
      b0_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      addr_cnt_q   <= '0;
      wrote_any_q  <= 1'b0;
      addr_q       <= '0;
      dout_q       <= '0;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      fmt_q        <= fmt_d;
      phase_q      <= phase_d;
      b0_q         <= b0_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_cnt_q   <= addr_cnt_d;
      wrote_any_q  <= wrote_any_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      we_q         <= we_d;
      frame_done_q <= frame_done_d;
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign addr       = addr_q;
  assign dout       = dout_q;
  assign we         = we_q;
  assign frame_done = frame_done_q;
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
  assign err        = err_q;
`endif

endmodule

// File: tb/tb_ov7670_capture_param.sv
// Scoreboard bench for ov7670_capture_param: two geometries share one camera bus,
// a frame-level model predicts every write, a monitor pops and compares on each we.
module tb_ov7670_capture_param;
  localparam int CH = 4;
  localparam int AW = 4;

  logic            pclk = 1'b0;
  logic            rst, vsync, href, fmt;
  logic [7:0]      d;
  logic [AW-1:0]   addr_a, addr_b;
  logic [3*CH-1:0] dout_a, dout_b;
  logic            we_a, we_b, fd_a, fd_b;
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
  logic            err_a, err_b;
`endif

  ov7670_capture_param #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIM(1), .CH_W(CH), .ADDR_W(AW)) dut_a (
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
    .err(err_a),
`endif
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d), .fmt(fmt),
    .addr(addr_a), .dout(dout_a), .we(we_a), .frame_done(fd_a)
  );

  ov7670_capture_param #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(2), .CH_W(CH), .ADDR_W(AW)) dut_b (
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
    .err(err_b),
`endif
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d), .fmt(fmt),
    .addr(addr_b), .dout(dout_b), .we(we_b), .frame_done(fd_b)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int addr;
    int dout;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   passed = 0;
  int   total  = 0;

  int   GH[2] = '{4, 8};
  int   GV[2] = '{2, 4};
  int   GD[2] = '{1, 2};

  bit   m_armed, m_fmt;
  int   m_y;
  int   m_addr[2];
  bit   m_wrote[2];
  bit   m_err[2];
  int   done_exp[2] = '{0, 0};
  int   done_seen[2] = '{0, 0};
  bit   fd_prev[2] = '{1'b0, 1'b0};
  logic [7:0] dir_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Expected pixel from the byte pair: top CH bits of each channel, or grey luma.
  function automatic int exp_pix(input bit f, input int b0, input int b1);
    int r, g, b, y;
    if (f) begin
      y = b0 >> (8 - CH);
      return (y << (2 * CH)) | (y << CH) | y;
    end
    r = (b0 >> 3) >> (5 - CH);
    g = (((b0 & 7) << 3) | (b1 >> 5)) >> (6 - CH);
    b = (b1 & 31) >> (5 - CH);
    return (r << (2 * CH)) | (g << CH) | b;
  endfunction

  task automatic push(input int k, input int a, input int dv);
    exp_t e;
    e.addr = a;
    e.dout = dv;
    if (k == 0) exp_a.push_back(e);
    else exp_b.push_back(e);
  endtask

  task automatic model_reset();
    m_armed = 0;
    m_fmt   = 0;
    m_y     = 0;
    for (int k = 0; k < 2; k++) begin
      m_addr[k]  = 0;
      m_wrote[k] = 0;
      m_err[k]   = 0;
    end
  endtask

  // Pixel p of line m_y is kept when in bounds and on the decimation grid.
  task automatic model_pairs(input logic [7:0] bq[$], input int lo, input int hi);
    for (int p = 0; lo + 2 * p + 1 < hi; p++) begin
      for (int k = 0; k < 2; k++) begin
        if (m_armed && m_y < GV[k] && p < GH[k] && (p % GD[k]) == 0 && (m_y % GD[k]) == 0) begin
          push(k, m_addr[k], exp_pix(m_fmt, int'(bq[lo + 2 * p]), int'(bq[lo + 2 * p + 1])));
          m_addr[k]++;
          m_wrote[k] = 1;
        end
      end
    end
  endtask

  task automatic do_vsync(input int n, input bit f);
    bit e[2];
    for (int k = 0; k < 2; k++) begin
      e[k] = m_wrote[k];
      done_exp[k] += int'(m_wrote[k]);
      m_wrote[k] = 0;
      m_err[k]   = 0;
      m_addr[k]  = 0;
    end
    m_armed = 1;
    m_fmt   = f;
    m_y     = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      if (i == 1) begin
        check("a_frame_done", fd_a, e[0]);
        check("b_frame_done", fd_b, e[1]);
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
        check("a_err_cleared", err_a, 0);
        check("b_err_cleared", err_b, 0);
`endif
      end
      if (i == 2) begin
        check("a_frame_done_1cyc", fd_a, 0);
        check("b_frame_done_1cyc", fd_b, 0);
      end
      rst   = 1'b0;
      vsync = 1'b1;
      fmt   = f;
      href  = (i > 0 && i < n - 1) ? 1'($urandom) : 1'b0;
      d     = 8'($urandom);
    end
    @(negedge pclk);
    vsync = 1'b0;
    href  = 1'b0;
  endtask

  // One href-high burst of n bytes; rst_at >= 0 pulses reset on that byte.
  task automatic send_line(input int n, input int rst_at);
    logic [7:0] bq[$];
    int seg;
    for (int i = 0; i < n; i++) bq.push_back((dir_q.size() > 0) ? dir_q.pop_front() : 8'($urandom));
    if (rst_at >= 0) begin
      model_pairs(bq, 0, rst_at);
      model_reset();
      model_pairs(bq, rst_at + 1, n);
      seg = n - rst_at - 1;
    end else begin
      model_pairs(bq, 0, n);
      seg = n;
    end
    for (int k = 0; k < 2; k++)
      if (seg != 2 * GH[k] && m_y < GV[k]) m_err[k] = 1;
    m_y++;
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      if (rst_at >= 0 && i == rst_at + 1) begin
        check("a_rst_we", we_a, 0);
        check("a_rst_addr", addr_a, 0);
        check("b_rst_we", we_b, 0);
        check("b_rst_addr", addr_b, 0);
      end
      rst   = (i == rst_at);
      vsync = 1'b0;
      href  = 1'b1;
      d     = bq[i];
      fmt   = 1'($urandom);
    end
    @(negedge pclk);
    rst  = 1'b0;
    href = 1'b0;
    d    = 8'($urandom);
    @(negedge pclk);
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
    check("a_err", err_a, m_err[0]);
    check("b_err", err_b, m_err[1]);
`endif
    @(negedge pclk);
  endtask

  always @(negedge pclk) begin
    exp_t e;
    if (we_a === 1'b1) begin
      check("a_we_expected", exp_a.size() > 0, 1);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check("a_addr", addr_a, e.addr);
        check("a_dout", dout_a, e.dout);
      end
    end
    if (we_b === 1'b1) begin
      check("b_we_expected", exp_b.size() > 0, 1);
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check("b_addr", addr_b, e.addr);
        check("b_dout", dout_b, e.dout);
      end
    end
    if (fd_a === 1'b1) begin
      done_seen[0]++;
      check("a_done_width", fd_prev[0], 0);
    end
    if (fd_b === 1'b1) begin
      done_seen[1]++;
      check("b_done_width", fd_prev[1], 0);
    end
    fd_prev[0] = (fd_a === 1'b1);
    fd_prev[1] = (fd_b === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    vsync = 1'b0;
    href  = 1'b0;
    fmt   = 1'b0;
    d     = 8'h00;
    model_reset();
    repeat (2) @(negedge pclk);
    check("a_reset_addr", addr_a, 0);
    check("a_reset_dout", dout_a, 0);
    check("a_reset_we", we_a, 0);
    check("a_reset_done", fd_a, 0);
    check("b_reset_we", we_b, 0);
    check("b_reset_done", fd_b, 0);
    rst = 1'b0;

    // Unarmed after reset: nothing may be written.
    send_line(8, -1);
    send_line(8, -1);

    // RGB565 frame with known colour bytes first.
    do_vsync(3, 1'b0);
    dir_q = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
    send_line(8, -1);
    send_line(8, -1);

    // Luma frame; fmt wanders during lines but must stay latched.
    do_vsync(4, 1'b1);
    dir_q = '{8'hA5, 8'h3C};
    send_line(8, -1);
    send_line(8, -1);

    // Full 8x4 frame for the decimating instance.
    do_vsync(3, 1'b0);
    repeat (4) send_line(16, -1);

    // Overlong line then extra lines beyond the frame.
    do_vsync(3, 1'b0);
    send_line(24, -1);
    repeat (3) send_line(8, -1);

    // Reset mid-line, then an unarmed line.
    do_vsync(3, 1'b1);
    send_line(8, 5);
    send_line(8, -1);
    do_vsync(3, 1'b0);
    send_line(8, -1);
    send_line(8, -1);

    for (int f = 0; f < 8; f++) begin
      int nl;
      do_vsync($urandom_range(3, 5), 1'($urandom));
      nl = $urandom_range(0, 6);
      for (int l = 0; l < nl; l++) begin
        if ($urandom_range(0, 9) == 0) send_line(10, 3);
        else send_line($urandom_range(1, 24), -1);
      end
    end

    do_vsync(3, 1'b0);
    repeat (4) @(negedge pclk);
    check("a_queue_drained", exp_a.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);
    check("a_done_count", done_seen[0], done_exp[0]);
    check("b_done_count", done_seen[1], done_exp[1]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
